// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one access per transaction onto a req/gnt/rvalid
// word bus, with byte-lane store mapping, extended load returns and trap detection.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic [4:0]      rsp_rd,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t state_q, state_d;

  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic            flushed_q, flushed_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [4:0]      rsp_rd_q, rsp_rd_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic accept;
  logic legal;

  function automatic logic access_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~off[0];
      3'b010:  ok = (off == 2'b00);
      3'b100:  ok = ~we;
      3'b101:  ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating across lanes lets the bus pick the bytes with mem_be alone.
  function automatic logic [XLEN-1:0] store_wdata(input logic [1:0] sz, input logic [XLEN-1:0] w);
    logic [XLEN-1:0] d;
    case (sz)
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] field;
    logic [XLEN-1:0] d;
    field = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  d = {{(XLEN-8){field[7]}}, field[7:0]};
      3'b001:  d = {{(XLEN-16){field[15]}}, field[15:0]};
      3'b100:  d = {{(XLEN-8){1'b0}}, field[7:0]};
      3'b101:  d = {{(XLEN-16){1'b0}}, field[15:0]};
      default: d = field;
    endcase
    return d;
  endfunction

  // A flush in IDLE blocks acceptance even though req_ready stays high.
  assign accept = req_valid && (state_q == S_IDLE) && !flush;
  assign legal  = access_ok(req_we, req_funct3, req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = legal ? S_REQ : S_RESP;
      S_REQ: begin
        if (mem_gnt)    state_d = we_q ? S_IDLE : S_WAIT;
        else if (flush) state_d = S_IDLE;
      end
      S_WAIT: if (mem_rvalid) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    flushed_d   = flushed_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = '0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    req_ready   = (state_q == S_IDLE);

    if (accept) begin
      we_d      = req_we;
      f3_d      = req_funct3;
      off_d     = req_addr[1:0];
      rd_d      = req_rd;
      flushed_d = 1'b0;
      err_d     = ~legal;
      done_d    = ~legal;
    end else if (flush && (state_q == S_REQ || state_q == S_WAIT)) begin
      flushed_d = 1'b1;
    end

    if (state_d == S_REQ) begin
      mem_req_d = 1'b1;
      if (state_q == S_IDLE) begin
        mem_we_d    = req_we;
        mem_be_d    = req_we ? store_be(req_funct3[1:0], req_addr[1:0]) : 4'b1111;
        mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
        mem_wdata_d = req_we ? store_wdata(req_funct3[1:0], req_wdata) : '0;
      end else begin
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
      end
    end

    // Store grant or flushed-before-grant both end the access from REQ.
    if (state_q == S_REQ && state_d == S_IDLE) done_d = 1'b1;

    if (state_q == S_WAIT && mem_rvalid) begin
      done_d = 1'b1;
      if (!flushed_q && !flush) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = load_extract(f3_q, off_q, mem_rdata);
        rsp_rd_d    = rd_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      rd_q        <= '0;
      flushed_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_rd_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      flushed_q   <= flushed_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // A flush arriving during RESP still cancels the visible pulses.
  assign rsp_valid = rsp_valid_q & ~flush;
  assign err       = err_q & ~flush;
  assign rsp_data  = rsp_data_q;
  assign rsp_rd    = rsp_rd_q;
  assign done      = done_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        done;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  mem_b [int unsigned];
  logic [31:0] last_rsp = '0;
  logic [4:0]  last_rd = '0;

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [7:0] fill;
    if (mem_b.exists(a)) return mem_b[a];
    fill = a[7:0] ^ 8'hA5;
    return fill;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & 32'hFFFF_FFFC;
    return {rd_byte(wa + 3), rd_byte(wa + 2), rd_byte(wa + 1), rd_byte(wa)};
  endfunction

  function automatic bit model_legal(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    if (f3[1:0] == 2'b11) return 1'b0;
    if (f3[2] && (we || f3[1])) return 1'b0;
    sz = 1 << f3[1:0];
    return (addr % sz) == 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < sz; i++) v = v | (32'(rd_byte(addr + i)) << (8 * i));
    if (!f3[2] && sz < 4 && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    return v;
  endfunction

  task automatic ready_for_next();
    req_valid = 1'b0;
    req_addr  = $urandom();
    req_wdata = $urandom();
  endtask

  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly);
    int unsigned sz;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] ev;
    sz = 1 << f3[1:0];
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    step();
    ready_for_next();
    chk("busy_ready", req_ready, 0);
    if (!model_legal(we, f3, addr)) begin
      chk("trap_no_req", mem_req, 0);
      chk("trap_err", err, 1);
      chk("trap_done", done, 1);
      chk("trap_rsp", rsp_valid, 0);
      step();
      chk("trap_ready", req_ready, 1);
      chk("trap_err_clr", err, 0);
      return;
    end
    ebe = '0;
    ewd = '0;
    if (we) begin
      for (int i = 0; i < sz; i++) ebe[(addr % 4) + i] = 1'b1;
      for (int j = 0; j < 4; j++) ewd[8*j +: 8] = wdata[8*(j % sz) +: 8];
    end else begin
      ebe = 4'b1111;
    end
    for (int k = 0; k <= gnt_dly; k++) begin
      chk("bus_req", mem_req, 1);
      chk("bus_we", mem_we, we);
      chk("bus_addr", mem_addr, addr & 32'hFFFF_FFFC);
      chk("bus_be", mem_be, ebe);
      if (we) chk("bus_wdata", mem_wdata, ewd);
      mem_gnt = (k == gnt_dly);
      step();
    end
    mem_gnt = 1'b0;
    chk("post_gnt_req", mem_req, 0);
    if (we) begin
      chk("st_done", done, 1);
      chk("st_ready", req_ready, 1);
      chk("st_rsp", rsp_valid, 0);
      for (int i = 0; i < sz; i++) mem_b[addr + i] = wdata[8*i +: 8];
      step();
      chk("st_done_clr", done, 0);
      return;
    end
    ev = model_load(f3, addr);
    for (int k = 0; k <= rv_dly; k++) begin
      chk("wait_done", done, 0);
      chk("wait_ready", req_ready, 0);
      mem_rvalid = (k == rv_dly);
      mem_rdata  = (k == rv_dly) ? word_at(addr) : $urandom();
      step();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom();
    chk("ld_rsp_valid", rsp_valid, 1);
    chk("ld_rsp_data", rsp_data, ev);
    chk("ld_rsp_rd", rsp_rd, rd);
    chk("ld_done", done, 1);
    chk("ld_err", err, 0);
    last_rsp = ev;
    last_rd  = rd;
    step();
    chk("ld_rsp_clr", rsp_valid, 0);
    chk("ld_ready", req_ready, 1);
    chk("ld_hold", rsp_data, last_rsp);
  endtask

  task automatic start_load(input logic [31:0] addr, input logic [4:0] rd);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = addr; req_rd = rd;
    step();
    ready_for_next();
  endtask

  initial begin
    // Reset state
    step();
    chk("rst_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", req_ready, 1);

    // LB / LBU sign and zero extension at byte 3
    mem_b[32'h1000] = 8'h56; mem_b[32'h1001] = 8'h34;
    mem_b[32'h1002] = 8'h12; mem_b[32'h1003] = 8'h80;
    do_access(1'b0, 3'b000, 32'h1003, 32'h0, 5'd7, 0, 0);
    chk("lb_value", rsp_data, 32'hFFFF_FF80);
    do_access(1'b0, 3'b100, 32'h1003, 32'h0, 5'd9, 0, 0);
    chk("lbu_value", rsp_data, 32'h0000_0080);

    // SH to upper half with a slow grant
    do_access(1'b1, 3'b001, 32'h2002, 32'hDEAD_BEEF, 5'd0, 3, 0);

    // Misaligned LW and an illegal width code
    do_access(1'b0, 3'b010, 32'h3001, 32'h0, 5'd3, 0, 0);
    do_access(1'b0, 3'b011, 32'h3000, 32'h0, 5'd3, 0, 0);

    // Flush in IDLE blocks acceptance
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h60; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_ready", req_ready, 1);
    chk("flush_idle_req", mem_req, 0);

    // Flush in REQ before grant
    start_load(32'h50, 5'd4);
    chk("flush_req_pre", mem_req, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_req_drop", mem_req, 0);
    chk("flush_req_done", done, 1);
    chk("flush_req_ready", req_ready, 1);
    chk("flush_req_rsp", rsp_valid, 0);
    step();
    chk("flush_req_done_clr", done, 0);

    // Flush in WAIT: rvalid consumed, response suppressed
    start_load(32'h54, 5'd5);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_wait_busy", req_ready, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    chk("flush_wait_done", done, 1);
    chk("flush_wait_rsp", rsp_valid, 0);
    chk("flush_wait_hold", rsp_data, last_rsp);
    chk("flush_wait_rd_hold", rsp_rd, last_rd);
    step();
    chk("flush_wait_ready", req_ready, 1);

    // Flush during RESP masks the pulse combinationally
    start_load(32'h58, 5'd6);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = word_at(32'h58);
    step();
    mem_rvalid = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_resp_rsp", rsp_valid, 0);
    chk("flush_resp_done", done, 1);
    step();
    flush = 1'b0;
    last_rsp = rsp_data;
    last_rd  = rsp_rd;
    chk("flush_resp_ready", req_ready, 1);

    // Stray rvalid in IDLE is ignored
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    chk("stray_rvalid_rsp", rsp_valid, 0);
    chk("stray_rvalid_done", done, 0);

    // Async reset during WAIT, then a late rvalid
    start_load(32'h5C, 5'd8);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready, 1);
    chk("arst_mem_req", mem_req, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_done", done, 0);
    step();
    rst_n = 1'b1;
    last_rsp = '0;
    last_rd  = '0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    chk("arst_late_rsp", rsp_valid, 0);
    chk("arst_late_done", done, 0);
    chk("arst_late_ready", req_ready, 1);

    // Back-to-back SW then LW of the same word
    do_access(1'b1, 3'b010, 32'h40, 32'h89AB_CDEF, 5'd0, 0, 0);
    do_access(1'b0, 3'b010, 32'h40, 32'h0, 5'd10, 0, 1);
    chk("sw_lw_value", rsp_data, 32'h89AB_CDEF);

    // Randomized mix against the memory model
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'h100 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      do_access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(),
                5'($urandom_range(0, 31)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
